// File: rtl/uart_ram_loader.sv
// UART (8N1, or 8E1 with UART_LOADER_PARITY_EN) to RAM loader: big-endian 16-bit word count,
// then big-endian 16-bit words written from BASE_ADDR, holding the CPU while a load runs.
module uart_ram_loader #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned REGISTER_COUNT = 4096,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned CLKS_PER_BIT   = 434
) (
  input  logic                              CLK_50,
  input  logic                              reset,
  input  logic                              rx,
  output logic                              ram_we,
  output logic [$clog2(REGISTER_COUNT)-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]             ram_wdata,
  output logic                              cpu_hold,
  output logic                              load_done,
  output logic                              frame_err
);

  localparam int unsigned AW   = $clog2(REGISTER_COUNT);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);
  localparam logic [AW-1:0]   BaseA  = AW'(BASE_ADDR);
  localparam logic [AW-1:0]   LastA  = AW'(REGISTER_COUNT - 1);

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_st_e;
  typedef enum logic [2:0] {LdLenHi, LdLenLo, LdDataHi, LdDataLo, LdDone} ld_st_e;

  rx_st_e          rx_st_q;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] bit_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      rx_shift_q;
`ifdef UART_LOADER_PARITY_EN
  logic            par_ok_q;
`endif

  logic stop_sample, byte_ok, byte_err;

  always_comb begin
    stop_sample = (rx_st_q == RxStop) && (bit_cnt_q == FullM1);
`ifdef UART_LOADER_PARITY_EN
    byte_ok     = stop_sample && rx_sync_q && par_ok_q;
`else
    byte_ok     = stop_sample && rx_sync_q;
`endif
    byte_err    = stop_sample && !byte_ok;
  end

  // Receiver: start bit qualified at mid-bit, then every bit sampled one bit period later.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RxIdle;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      rx_shift_q <= '0;
`ifdef UART_LOADER_PARITY_EN
      par_ok_q   <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      unique case (rx_st_q)
        RxIdle: begin
          bit_cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) rx_st_q <= RxStart;
        end
        RxStart: begin
          if (bit_cnt_q == HalfM1) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            rx_st_q   <= rx_sync_q ? RxIdle : RxData;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (bit_cnt_q == FullM1) begin
            bit_cnt_q  <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            bit_idx_q  <= bit_idx_q + 1'b1;
`ifdef UART_LOADER_PARITY_EN
            if (bit_idx_q == 3'd7) rx_st_q <= RxParity;
`else
            if (bit_idx_q == 3'd7) rx_st_q <= RxStop;
`endif
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        RxParity: begin
          if (bit_cnt_q == FullM1) begin
            bit_cnt_q <= '0;
`ifdef UART_LOADER_PARITY_EN
            par_ok_q  <= (rx_sync_q == ^rx_shift_q);
`endif
            rx_st_q   <= RxStop;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (bit_cnt_q == FullM1) rx_st_q <= RxIdle;
          else                     bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        default: rx_st_q <= RxIdle;
      endcase
    end
  end

  ld_st_e          ld_st_q;
  logic            ram_we_q, cpu_hold_q, load_done_q, frame_err_q;
  logic [AW-1:0]   ram_addr_q, next_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic [7:0]      len_hi_q, data_hi_q;
  logic [15:0]     remain_q;

  // Loader: ram_addr only moves on a write so it holds the last written address in between.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      ld_st_q     <= LdLenHi;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= BaseA;
      next_addr_q <= BaseA;
      ram_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      len_hi_q    <= '0;
      data_hi_q   <= '0;
      remain_q    <= '0;
    end else begin
      ram_we_q <= 1'b0;
      // Final write of a load is on the bus this cycle; release the CPU on the next.
      if (ram_we_q && remain_q == 16'd0) begin
        load_done_q <= 1'b1;
        cpu_hold_q  <= 1'b0;
      end
      if (byte_err) begin
        frame_err_q <= 1'b1;
        cpu_hold_q  <= 1'b0;
        ld_st_q     <= LdLenHi;
      end else if (byte_ok) begin
        unique case (ld_st_q)
          LdLenHi, LdDone: begin
            len_hi_q    <= rx_shift_q;
            next_addr_q <= BaseA;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            ld_st_q     <= LdLenLo;
          end
          LdLenLo: begin
            if ({len_hi_q, rx_shift_q} == 16'd0) begin
              load_done_q <= 1'b1;
              cpu_hold_q  <= 1'b0;
              ld_st_q     <= LdDone;
            end else begin
              remain_q <= {len_hi_q, rx_shift_q};
              ld_st_q  <= LdDataHi;
            end
          end
          LdDataHi: begin
            data_hi_q <= rx_shift_q;
            ld_st_q   <= LdDataLo;
          end
          LdDataLo: begin
            ram_we_q    <= 1'b1;
            ram_wdata_q <= DATA_WIDTH'({data_hi_q, rx_shift_q});
            ram_addr_q  <= next_addr_q;
            next_addr_q <= (next_addr_q == LastA) ? '0 : next_addr_q + 1'b1;
            remain_q    <= remain_q - 1'b1;
            ld_st_q     <= (remain_q == 16'd1) ? LdDone : LdDataHi;
          end
          default: ld_st_q <= LdLenHi;
        endcase
      end
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign frame_err = frame_err_q;

endmodule
